mul_control: RTL and testbench

- Sequencing controller for the shift-add multiplier datapath. It drives the Product register's load (`wrctrl`), store-and-shift (`strctrl`) and `ready` controls, plus the ALU add/pass select.
- It turns a single `start` request into one load cycle, then WIDTH add-shift cycles, then a completion handshake.
- It sits between the top-level multiplier wrapper and the Product register / ALU instances.

---
 rtl/mul_control_if.sv | 29 ++
 rtl/mul_control.sv | 104 ++++++++++
 tb/tb_mul_control.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/mul_control_if.sv
// Handshake/control bundle between the multiplier wrapper and mul_control.
//   master : wrapper side; drives start/abort and feeds back Product bit 0.
//   slave  : controller side; drives the Product/ALU strobes and status.
//   start, abort, product_lsb : requests and feedback into the controller
//   wrctrl, strctrl, alu_add  : Product load/shift strobes and ALU select
//   ready, busy, step         : status and current iteration index
interface mul_control_if #(
    parameter int unsigned CNT_W = 6
);
    logic             start;
    logic             abort;
    logic             product_lsb;
    logic             wrctrl;
    logic             strctrl;
    logic             alu_add;
    logic             ready;
    logic             busy;
    logic [CNT_W-1:0] step;

    modport master (
        output start, abort, product_lsb,
        input  wrctrl, strctrl, alu_add, ready, busy, step
    );

    modport slave (
        input  start, abort, product_lsb,
        output wrctrl, strctrl, alu_add, ready, busy, step
    );
endinterface

// File: rtl/mul_control.sv
// Sequencing controller for the shift-add multiplier datapath.
// A sampled start produces one Product load cycle (wrctrl), then WIDTH
// add-shift cycles (strctrl, with alu_add following the current multiplier
// bit), then holds ready until the next start.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : mul_control_if.slave (start/abort/product_lsb in;
//          wrctrl/strctrl/alu_add/ready/busy/step out)
// CNT_W must satisfy 2**CNT_W > WIDTH.
module mul_control #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic          clk,
    input  logic          rst,
    mul_control_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] step_q, step_d;

    // State register and iteration counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
        end
    end

    // Next-state and next-step logic; abort outranks every other request
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        if (bus.abort) begin
            state_d = IDLE;
            step_d  = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.start) state_d = LOAD;
                end
                LOAD: begin
                    state_d = RUN;
                    step_d  = '0;
                end
                RUN: begin
                    if (step_q == LAST_STEP) begin
                        state_d = DONE;
                        step_d  = '0;
                    end else begin
                        step_d = step_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (bus.start) state_d = LOAD;
                end
                default: begin
                    state_d = IDLE;
                    step_d  = '0;
                end
            endcase
        end
    end

    // Output decode: Moore strobes, alu_add follows product_lsb during RUN
    always_comb begin
        bus.wrctrl  = 1'b0;
        bus.strctrl = 1'b0;
        bus.alu_add = 1'b0;
        bus.ready   = 1'b0;
        bus.busy    = 1'b0;
        unique case (state_q)
            LOAD: begin
                bus.wrctrl = 1'b1;
                bus.busy   = 1'b1;
            end
            RUN: begin
                bus.strctrl = 1'b1;
                bus.busy    = 1'b1;
                bus.alu_add = bus.product_lsb;
            end
            DONE: begin
                bus.ready = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.step = step_q;

endmodule

// File: tb/tb_mul_control.sv
// Directed bench for mul_control: a WIDTH=32 instance and a WIDTH=4 instance,
// each driving a small Product register / ALU model from the DUT strobes.
module tb_mul_control;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mul_control_if #(.CNT_W(6)) bus32 ();
    mul_control_if #(.CNT_W(3)) bus4 ();

    mul_control #(.WIDTH(32), .CNT_W(6)) dut32 (.clk(clk), .rst(rst), .bus(bus32));
    mul_control #(.WIDTH(4),  .CNT_W(3)) dut4  (.clk(clk), .rst(rst), .bus(bus4));

    // Product register + ALU model, WIDTH=32
    logic [31:0] mcand32 = '0;
    logic [31:0] mult32  = '0;
    logic [63:0] prod32  = '0;
    logic [32:0] sum32;
    assign sum32 = {1'b0, prod32[63:32]} + (bus32.alu_add ? {1'b0, mcand32} : 33'd0);
    assign bus32.product_lsb = prod32[0];
    always @(posedge clk) begin
        if (bus32.wrctrl)       prod32 <= {32'd0, mult32};
        else if (bus32.strctrl) prod32 <= {sum32, prod32[31:1]};
    end

    // Product register + ALU model, WIDTH=4
    logic [3:0] mcand4 = '0;
    logic [3:0] mult4  = '0;
    logic [7:0] prod4  = '0;
    logic [4:0] sum4;
    assign sum4 = {1'b0, prod4[7:4]} + (bus4.alu_add ? {1'b0, mcand4} : 5'd0);
    assign bus4.product_lsb = prod4[0];
    always @(posedge clk) begin
        if (bus4.wrctrl)       prod4 <= {4'd0, mult4};
        else if (bus4.strctrl) prod4 <= {sum4, prod4[3:1]};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic seen;

        bus32.start = 1'b1;
        bus32.abort = 1'b0;
        bus4.start  = 1'b0;
        bus4.abort  = 1'b0;

        // Reset held with start high
        tick();
        tick();
        check("rst_wrctrl",  64'(bus32.wrctrl),  64'd0);
        check("rst_strctrl", 64'(bus32.strctrl), 64'd0);
        check("rst_ready",   64'(bus32.ready),   64'd0);
        check("rst_busy",    64'(bus32.busy),    64'd0);
        check("rst_alu_add", 64'(bus32.alu_add), 64'd0);
        check("rst_step",    64'(bus32.step),    64'd0);
        bus32.start = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        check("post_rst_idle", 64'(bus32.busy), 64'd0);

        // abort beats start in IDLE
        bus32.start = 1'b1;
        bus32.abort = 1'b1;
        tick();
        check("abort_prio_wrctrl", 64'(bus32.wrctrl), 64'd0);
        check("abort_prio_busy",   64'(bus32.busy),   64'd0);
        bus32.abort = 1'b0;

        // 12 x 13
        mcand32 = 32'd12;
        mult32  = 32'd13;
        tick();
        bus32.start = 1'b0;
        check("mul1_wrctrl",  64'(bus32.wrctrl),  64'd1);
        check("mul1_strctrl", 64'(bus32.strctrl), 64'd0);
        check("mul1_busy",    64'(bus32.busy),    64'd1);
        for (int i = 0; i < 32; i++) begin
            tick();
            check("mul1_run_strctrl", 64'(bus32.strctrl), 64'd1);
            check("mul1_run_step",    64'(bus32.step),    64'(i));
            check("mul1_run_alu_add", 64'(bus32.alu_add), 64'(mult32[i]));
        end
        tick();
        check("mul1_ready",   64'(bus32.ready),   64'd1);
        check("mul1_strctrl_off", 64'(bus32.strctrl), 64'd0);
        check("mul1_busy_off", 64'(bus32.busy),   64'd0);
        check("mul1_product", prod32,             64'd156);
        tick();
        check("mul1_ready_hold", 64'(bus32.ready), 64'd1);

        // Back-to-back: start from DONE
        mcand32 = 32'hFFFF_FFFF;
        mult32  = 32'hFFFF_FFFF;
        bus32.start = 1'b1;
        tick();
        bus32.start = 1'b0;
        check("b2b_ready_drop", 64'(bus32.ready),  64'd0);
        check("b2b_wrctrl",     64'(bus32.wrctrl), 64'd1);
        for (int i = 0; i < 32; i++) begin
            tick();
            check("b2b_run_strctrl", 64'(bus32.strctrl), 64'd1);
        end
        tick();
        check("b2b_ready",   64'(bus32.ready), 64'd1);
        check("b2b_product", prod32,           64'hFFFF_FFFE_0000_0001);

        // start pulsed during RUN is ignored
        mcand32 = 32'd12;
        mult32  = 32'd13;
        bus32.start = 1'b1;
        tick();
        bus32.start = 1'b0;
        check("srun_wrctrl", 64'(bus32.wrctrl), 64'd1);
        for (int i = 0; i < 32; i++) begin
            tick();
            check("srun_step",   64'(bus32.step),   64'(i));
            check("srun_wrctrl_low", 64'(bus32.wrctrl), 64'd0);
            bus32.start = (i == 10);
        end
        tick();
        check("srun_ready",   64'(bus32.ready), 64'd1);
        check("srun_product", prod32,           64'd156);
        tick();
        check("srun_ready_hold", 64'(bus32.ready),  64'd1);
        check("srun_no_reload",  64'(bus32.wrctrl), 64'd0);

        // abort at step 5
        bus32.start = 1'b1;
        tick();
        bus32.start = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check("abort_at_step", 64'(bus32.step), 64'd5);
        bus32.abort = 1'b1;
        tick();
        bus32.abort = 1'b0;
        check("abort_strctrl", 64'(bus32.strctrl), 64'd0);
        check("abort_step",    64'(bus32.step),    64'd0);
        check("abort_busy",    64'(bus32.busy),    64'd0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus32.ready) seen = 1'b1;
        end
        check("abort_no_ready", 64'(seen), 64'd0);

        // asynchronous reset at step 20
        bus32.start = 1'b1;
        tick();
        bus32.start = 1'b0;
        for (int i = 0; i < 21; i++) tick();
        check("arst_at_step", 64'(bus32.step), 64'd20);
        rst = 1'b0;
        #1;
        check("arst_strctrl", 64'(bus32.strctrl), 64'd0);
        check("arst_busy",    64'(bus32.busy),    64'd0);
        check("arst_step",    64'(bus32.step),    64'd0);
        tick();
        rst = 1'b1;
        tick();

        // WIDTH=4: 5 x 3
        mcand4 = 4'd5;
        mult4  = 4'd3;
        bus4.start = 1'b1;
        tick();
        bus4.start = 1'b0;
        check("w4_wrctrl", 64'(bus4.wrctrl), 64'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("w4_strctrl", 64'(bus4.strctrl), 64'd1);
            check("w4_step",    64'(bus4.step),    64'(i));
        end
        tick();
        check("w4_ready",       64'(bus4.ready),   64'd1);
        check("w4_strctrl_off", 64'(bus4.strctrl), 64'd0);
        check("w4_product",     64'(prod4),        64'd15);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
